// File: rtl/tri_raster_scheduler.sv
// Triangle raster scheduler: clips the bounding box, walks it row-major through the coverage tester
// and streams covered pixels downstream. Optional macro TRI_RASTER_COUNT_EN adds cov_count_out.
module tri_raster_scheduler #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        tri_valid_in,
    output logic        tri_ready_out,
    input  logic [8:0]  v1_in [2:0],
    input  logic [8:0]  v2_in [2:0],
    input  logic [8:0]  v3_in [2:0],
    output logic [8:0]  test_v1_out [2:0],
    output logic [8:0]  test_v2_out [2:0],
    output logic [8:0]  test_v3_out [2:0],
    output logic [8:0]  test_x_out,
    output logic [8:0]  test_y_out,
    output logic        test_valid_out,
    input  logic        test_in_tri_in,
    input  logic        test_valid_in,
    output logic [8:0]  px_x_out,
    output logic [8:0]  px_y_out,
    output logic        px_valid_out,
    input  logic        px_ready_in,
    output logic        busy_out,
    output logic        done_out
`ifdef TRI_RASTER_COUNT_EN
    ,
    output logic [17:0] cov_count_out
`endif
);

    localparam logic [8:0] X_LIM = 9'(SCREEN_W - 1);
    localparam logic [8:0] Y_LIM = 9'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BBOX  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_EMIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t     state_r, state_nx, adv_state_s;
    logic [8:0] v1_r [2:0];
    logic [8:0] v2_r [2:0];
    logic [8:0] v3_r [2:0];
    logic [8:0] xmin_r, xmax_r, ymin_r, ymax_r;
    logic [8:0] xmin_s, xmax_s, ymin_s, ymax_s, xmax_raw_s, ymax_raw_s;
    logic [8:0] cur_x_r, cur_y_r, cur_x_nx, cur_y_nx, adv_x_s, adv_y_s;
    logic [8:0] px_x_r, px_y_r;
    logic       tri_ready_r, busy_r, test_valid_r, px_valid_r, done_r;
    logic       accept_s, hit_s;

    function automatic logic [8:0] min3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        logic [8:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [8:0] max3(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c);
        logic [8:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    assign accept_s = tri_valid_in && tri_ready_r;
    assign hit_s    = (state_r == S_WAIT) && test_valid_in && test_in_tri_in;

    // Bounding box of the latched vertices; only the upper bound is clipped, the lower bound decides off-screen
    always_comb begin
        xmin_s     = min3(v1_r[2], v2_r[2], v3_r[2]);
        ymin_s     = min3(v1_r[1], v2_r[1], v3_r[1]);
        xmax_raw_s = max3(v1_r[2], v2_r[2], v3_r[2]);
        ymax_raw_s = max3(v1_r[1], v2_r[1], v3_r[1]);
        xmax_s     = (xmax_raw_s > X_LIM) ? X_LIM : xmax_raw_s;
        ymax_s     = (ymax_raw_s > Y_LIM) ? Y_LIM : ymax_raw_s;
    end

    // Advance to the next pixel; compare before incrementing so 9-bit counters never wrap
    always_comb begin
        adv_state_s = S_DONE;
        adv_x_s     = cur_x_r;
        adv_y_s     = cur_y_r;
        if (cur_x_r < xmax_r) begin
            adv_state_s = S_ISSUE;
            adv_x_s     = cur_x_r + 9'd1;
        end else if (cur_y_r < ymax_r) begin
            adv_state_s = S_ISSUE;
            adv_x_s     = xmin_r;
            adv_y_s     = cur_y_r + 9'd1;
        end else begin
            adv_state_s = S_DONE;
        end
    end

    // Next-state and cursor logic
    always_comb begin
        state_nx = state_r;
        cur_x_nx = cur_x_r;
        cur_y_nx = cur_y_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nx = S_BBOX;
                else          state_nx = S_IDLE;
            end
            S_BBOX: begin
                if ((xmin_s > X_LIM) || (ymin_s > Y_LIM)) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_ISSUE;
                    cur_x_nx = xmin_s;
                    cur_y_nx = ymin_s;
                end
            end
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (test_valid_in && test_in_tri_in) begin
                    state_nx = S_EMIT;
                end else if (test_valid_in) begin
                    state_nx = adv_state_s;
                    cur_x_nx = adv_x_s;
                    cur_y_nx = adv_y_s;
                end else begin
                    state_nx = S_WAIT;
                end
            end
            S_EMIT: begin
                if (px_ready_in) begin
                    state_nx = adv_state_s;
                    cur_x_nx = adv_x_s;
                    cur_y_nx = adv_y_s;
                end else begin
                    state_nx = S_EMIT;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_r <= S_IDLE;
        else        state_r <= state_nx;
    end

    // Control outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tri_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            test_valid_r <= 1'b0;
            px_valid_r   <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            tri_ready_r  <= (state_nx == S_IDLE);
            busy_r       <= (state_nx != S_IDLE);
            test_valid_r <= (state_nx == S_ISSUE);
            px_valid_r   <= (state_nx == S_EMIT);
            done_r       <= (state_nx == S_DONE);
        end
    end

    // Vertex latch, box bounds, cursor and covered-pixel data
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            v1_r    <= '{9'd0, 9'd0, 9'd0};
            v2_r    <= '{9'd0, 9'd0, 9'd0};
            v3_r    <= '{9'd0, 9'd0, 9'd0};
            xmin_r  <= 9'd0;
            xmax_r  <= 9'd0;
            ymin_r  <= 9'd0;
            ymax_r  <= 9'd0;
            cur_x_r <= 9'd0;
            cur_y_r <= 9'd0;
            px_x_r  <= 9'd0;
            px_y_r  <= 9'd0;
        end else begin
            if (accept_s) begin
                v1_r <= v1_in;
                v2_r <= v2_in;
                v3_r <= v3_in;
            end
            if (state_r == S_BBOX) begin
                xmin_r <= xmin_s;
                xmax_r <= xmax_s;
                ymin_r <= ymin_s;
                ymax_r <= ymax_s;
            end
            cur_x_r <= cur_x_nx;
            cur_y_r <= cur_y_nx;
            if (hit_s) begin
                px_x_r <= cur_x_r;
                px_y_r <= cur_y_r;
            end
        end
    end

`ifdef TRI_RASTER_COUNT_EN
    logic [17:0] cov_count_r;

    // Covered-pixel count for the current triangle, held after DONE until the next accept
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cov_count_r <= 18'd0;
        end else if (accept_s) begin
            cov_count_r <= 18'd0;
        end else if ((state_r == S_EMIT) && px_ready_in) begin
            cov_count_r <= cov_count_r + 18'd1;
        end
    end

    assign cov_count_out = cov_count_r;
`endif

    assign tri_ready_out  = tri_ready_r;
    assign busy_out       = busy_r;
    assign test_valid_out = test_valid_r;
    assign px_valid_out   = px_valid_r;
    assign done_out       = done_r;
    assign test_x_out     = cur_x_r;
    assign test_y_out     = cur_y_r;
    assign px_x_out       = px_x_r;
    assign px_y_out       = px_y_r;
    assign test_v1_out    = v1_r;
    assign test_v2_out    = v2_r;
    assign test_v3_out    = v3_r;

endmodule

// File: tb/tb_tri_raster_scheduler.sv
// Scoreboard bench for tri_raster_scheduler: a reference model queues the expected test and pixel
// streams, a tester model answers with random latency, monitors pop and compare.
`timescale 1ns/1ps
module tb_tri_raster_scheduler;
    localparam int W = 320;
    localparam int H = 240;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        tri_valid_in;
    logic        tri_ready_out;
    logic [8:0]  v1_in [2:0];
    logic [8:0]  v2_in [2:0];
    logic [8:0]  v3_in [2:0];
    logic [8:0]  test_v1_out [2:0];
    logic [8:0]  test_v2_out [2:0];
    logic [8:0]  test_v3_out [2:0];
    logic [8:0]  test_x_out, test_y_out, px_x_out, px_y_out;
    logic        test_valid_out, test_in_tri_in, test_valid_in;
    logic        px_valid_out, px_ready_in, busy_out, done_out;
`ifdef TRI_RASTER_COUNT_EN
    logic [17:0] cov_count_out;
`endif

    tri_raster_scheduler #(.SCREEN_W(W), .SCREEN_H(H)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .tri_valid_in(tri_valid_in), .tri_ready_out(tri_ready_out),
        .v1_in(v1_in), .v2_in(v2_in), .v3_in(v3_in),
        .test_v1_out(test_v1_out), .test_v2_out(test_v2_out), .test_v3_out(test_v3_out),
        .test_x_out(test_x_out), .test_y_out(test_y_out), .test_valid_out(test_valid_out),
        .test_in_tri_in(test_in_tri_in), .test_valid_in(test_valid_in),
        .px_x_out(px_x_out), .px_y_out(px_y_out), .px_valid_out(px_valid_out),
        .px_ready_in(px_ready_in), .busy_out(busy_out), .done_out(done_out)
`ifdef TRI_RASTER_COUNT_EN
        , .cov_count_out(cov_count_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0, n_fail = 0;
    int exp_test[$];
    int exp_px[$];
    int tax, tay, tbx, tby, tcx, tcy;
    int tmode = 0, bp_mode = 0, lat_max = 4;
    bit held = 1'b0, outstanding = 1'b0;
    int cyc = 0, iss_cnt = 0, pxacc_cnt = 0, done_cnt = 0, done_cyc = 0, first_test_cyc = -1, acc_cyc = 0;
    int ncov = 0, nt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int edge_fn(input int ax, input int ay, input int bx, input int by, input int px, input int py);
        return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
    endfunction

    // Inclusive coverage test, either winding
    function automatic bit in_tri(input int px, input int py);
        int e1, e2, e3;
        e1 = edge_fn(tax, tay, tbx, tby, px, py);
        e2 = edge_fn(tbx, tby, tcx, tcy, px, py);
        e3 = edge_fn(tcx, tcy, tax, tay, px, py);
        return ((e1 >= 0) && (e2 >= 0) && (e3 >= 0)) || ((e1 <= 0) && (e2 <= 0) && (e3 <= 0));
    endfunction

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    // Tester model: one verdict per launched test after 1..lat_max cycles
    initial begin
        int tx, ty, lat;
        test_valid_in = 1'b0;
        test_in_tri_in = 1'b0;
        forever begin
            @(negedge clk_in);
            if (test_valid_out && !rst_in) begin
                tx = int'(test_x_out);
                ty = int'(test_y_out);
                lat = $urandom_range(1, lat_max);
                repeat (lat) @(posedge clk_in);
                #1;
                test_valid_in = 1'b1;
                test_in_tri_in = (tmode != 0) ? in_tri(tx, ty) : 1'b0;
                @(posedge clk_in);
                #1;
                test_valid_in = 1'b0;
                test_in_tri_in = 1'b0;
                outstanding = 1'b0;
            end
        end
    end

    // Downstream ready: always, random, or a 5-cycle stall on the first covered pixel
    initial begin
        px_ready_in = 1'b1;
        forever begin
            @(posedge clk_in);
            #1;
            if (bp_mode == 1) begin
                px_ready_in = 1'($urandom_range(0, 1));
            end else if (bp_mode == 2 && px_valid_out && !held) begin
                px_ready_in = 1'b0;
                repeat (5) @(posedge clk_in);
                #1;
                px_ready_in = 1'b1;
                held = 1'b1;
            end else begin
                px_ready_in = 1'b1;
            end
        end
    end

    // Monitor: compares tests and pixel handshakes against the scoreboard queues
    initial begin
        bit prev_pv, prev_acc;
        int prev_xy, e;
        prev_pv = 1'b0; prev_acc = 1'b0; prev_xy = 0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                prev_pv = 1'b0;
                continue;
            end
            check("ready_vs_busy", int'(tri_ready_out), int'(!busy_out));
            if (test_valid_out) begin
                check("one_outstanding", int'(outstanding), 0);
                check("no_test_during_emit", int'(px_valid_out), 0);
                check("test_x_clipped", int'(test_x_out < 9'(W)), 1);
                check("test_vertices", int'(test_v1_out[2]) + int'(test_v2_out[1]) * 512 + int'(test_v3_out[2]) * 262144,
                      tax + tby * 512 + tcx * 262144);
                if (exp_test.size() == 0) begin
                    check("extra_test", int'(test_x_out) * 1024 + int'(test_y_out), -1);
                end else begin
                    e = exp_test.pop_front();
                    check("test_xy", int'(test_x_out) * 1024 + int'(test_y_out), e);
                end
                if (first_test_cyc < 0) first_test_cyc = cyc;
                outstanding = 1'b1;
                iss_cnt++;
            end
            if (px_valid_out && prev_pv && !prev_acc)
                check("px_stable", int'(px_x_out) * 1024 + int'(px_y_out), prev_xy);
            if (px_valid_out && px_ready_in) begin
                if (exp_px.size() == 0) begin
                    check("extra_px", int'(px_x_out) * 1024 + int'(px_y_out), -1);
                end else begin
                    e = exp_px.pop_front();
                    check("px_xy", int'(px_x_out) * 1024 + int'(px_y_out), e);
                end
                pxacc_cnt++;
            end
            prev_pv = px_valid_out;
            prev_acc = px_ready_in;
            prev_xy = int'(px_x_out) * 1024 + int'(px_y_out);
            if (done_out) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // Reference model + triangle launch
    task automatic launch_tri(input int ax, input int ay, input int bx, input int by,
                              input int cx, input int cy, input int tm, input int bp);
        int xmn, xmx, ymn, ymx;
        tax = ax; tay = ay; tbx = bx; tby = by; tcx = cx; tcy = cy;
        tmode = tm; bp_mode = bp; held = 1'b0;
        xmn = (ax < bx) ? ax : bx; xmn = (xmn < cx) ? xmn : cx;
        ymn = (ay < by) ? ay : by; ymn = (ymn < cy) ? ymn : cy;
        xmx = (ax > bx) ? ax : bx; xmx = (xmx > cx) ? xmx : cx;
        ymx = (ay > by) ? ay : by; ymx = (ymx > cy) ? ymx : cy;
        if (xmx > W - 1) xmx = W - 1;
        if (ymx > H - 1) ymx = H - 1;
        nt = 0; ncov = 0;
        if (xmn <= W - 1 && ymn <= H - 1) begin
            for (int y = ymn; y <= ymx; y++) begin
                for (int x = xmn; x <= xmx; x++) begin
                    exp_test.push_back(x * 1024 + y);
                    nt++;
                    if (tm != 0 && in_tri(x, y)) begin
                        exp_px.push_back(x * 1024 + y);
                        ncov++;
                    end
                end
            end
        end
        first_test_cyc = -1;
        @(posedge clk_in);
        #1;
        v1_in[2] = 9'(ax); v1_in[1] = 9'(ay); v1_in[0] = 9'($urandom_range(0, 511));
        v2_in[2] = 9'(bx); v2_in[1] = 9'(by); v2_in[0] = 9'($urandom_range(0, 511));
        v3_in[2] = 9'(cx); v3_in[1] = 9'(cy); v3_in[0] = 9'($urandom_range(0, 511));
        tri_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        acc_cyc = cyc;
        tri_valid_in = 1'b0;
        check("ready_low_after_accept", int'(tri_ready_out), 0);
    endtask

    task automatic run_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy, input int tm, input int bp);
        int d0, i0, p0;
        d0 = done_cnt; i0 = iss_cnt; p0 = pxacc_cnt;
        launch_tri(ax, ay, bx, by, cx, cy, tm, bp);
        for (int i = 0; i < 20000 && done_cnt == d0; i++) @(posedge clk_in);
        repeat (3) @(posedge clk_in);
        #1;
        check("done_once", done_cnt, d0 + 1);
        check("tests_issued", iss_cnt - i0, nt);
        check("px_emitted", pxacc_cnt - p0, ncov);
        check("tests_left", exp_test.size(), 0);
        check("px_left", exp_px.size(), 0);
        check("no_outstanding_at_done", int'(outstanding), 0);
        check("ready_after_done", int'(tri_ready_out), 1);
        if (nt > 0) check("first_test_latency", first_test_cyc - acc_cyc, 1);
        else        check("offscreen_done_latency", done_cyc - acc_cyc, 1);
`ifdef TRI_RASTER_COUNT_EN
        check("cov_count", int'(cov_count_out), ncov);
`endif
        exp_test.delete();
        exp_px.delete();
    endtask

    initial begin
        int d0, i0, bx0, by0;
        rst_in = 1'b1;
        tri_valid_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v1_in[k] = 9'd0; v2_in[k] = 9'd0; v3_in[k] = 9'd0;
        end
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_ready", int'(tri_ready_out), 1);
        check("rst_outputs", int'({busy_out, done_out, test_valid_out, px_valid_out}), 0);
        check("rst_coords", int'(test_x_out) + int'(test_y_out) + int'(px_x_out) + int'(px_y_out), 0);
        rst_in = 1'b0;

        run_tri(10, 10, 12, 10, 10, 12, 0, 0);   // always-miss walk
        run_tri(10, 10, 12, 10, 10, 12, 1, 0);   // real tester
        run_tri(10, 10, 12, 10, 10, 12, 1, 2);   // 5-cycle stall on first pixel
        run_tri(300, 20, 400, 25, 310, 30, 1, 0); // x clipped
        run_tri(320, 5, 330, 6, 400, 7, 1, 0);   // fully off-screen
        run_tri(5, 235, 9, 250, 2, 245, 1, 1);   // y clipped
        run_tri(50, 60, 50, 60, 50, 60, 1, 0);   // degenerate point
        for (int t = 0; t < 8; t++) begin
            bx0 = $urandom_range(0, 320);
            by0 = $urandom_range(0, 240);
            lat_max = $urandom_range(1, 5);
            run_tri(bx0 + $urandom_range(0, 6), by0 + $urandom_range(0, 6),
                    bx0 + $urandom_range(0, 6), by0 + $urandom_range(0, 6),
                    bx0 + $urandom_range(0, 6), by0 + $urandom_range(0, 6),
                    ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 1));
        end

        // Abort mid-row, then a fresh triangle must start at its own box corner
        lat_max = 4;
        d0 = done_cnt; i0 = iss_cnt;
        launch_tri(100, 100, 110, 100, 100, 110, 1, 0);
        for (int i = 0; i < 200 && iss_cnt < i0 + 3; i++) @(posedge clk_in);
        @(posedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check("abort_ready", int'(tri_ready_out), 1);
        check("abort_outputs", int'({busy_out, done_out, test_valid_out, px_valid_out}), 0);
        check("abort_coords", int'(test_x_out) + int'(test_y_out), 0);
        repeat (10) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        exp_test.delete();
        exp_px.delete();
        outstanding = 1'b0;
        check("no_done_on_abort", done_cnt, d0);
        run_tri(20, 30, 23, 30, 20, 33, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
